mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one unified memory port between the RV64I datapath's instruction-fetch
// stage (read-only, 32-bit) and its MEM stage (64-bit read/write).
// Sequences each transaction through a req/ack handshake with the memory.
// Enforces data-over-fetch priority with a starvation guard and an ack timeout.
// Returns per-stage stall signals to the pipeline hazard logic.
// PARAMETERS
// MAX_D_STREAK  4    consecutive data grants allowed while if_req waits; 0 = fetch never forced
// TIMEOUT       255  BUSY cycles without m_ack before abort; 0 = no timeout
// PORTS
// clk        in   1   clock, all state updates on rising edge
// rst        in   1   synchronous, active-high reset
// if_req     in   1   fetch request; held with if_addr until if_valid
// if_addr    in   64  fetch byte address
// if_rdata   out  32  fetched instruction, valid with if_valid
// if_valid   out  1   one-cycle response pulse for fetch
// if_err     out  1   fetch aborted by timeout; qualifies if_valid
// d_req      in   1   data request; d_* held stable until d_valid
// d_we       in   1   1 = write, 0 = read
// d_addr     in   64  data byte address
// d_wdata    in   64  write data
// d_wstrb    in   8   byte write enables
// d_rdata    out  64  read data, valid with d_valid
// d_valid    out  1   one-cycle response pulse for data
// d_err      out  1   data access aborted by timeout; qualifies d_valid
// stall_if   out  1   if_req & ~if_valid (combinational)
// stall_mem  out  1   d_req & ~d_valid (combinational)
// m_req      out  1   memory request, held until m_ack
// m_we       out  1   memory write enable
// m_addr     out  64  memory address, bits [2:0] forced to 0
// m_wdata    out  64  memory write data
// m_wstrb    out  8   memory byte strobes; 0 for reads
// m_ack      in   1   memory completion; sampled only while m_req=1
// m_rdata    in   64  memory read data; valid with m_ack
// BEHAVIOUR
// - FSM states: IDLE -> BUSY -> RESP -> IDLE.
// - Reset values: all outputs 0, state IDLE, streak and timeout counters 0.
// - IDLE, any req present: pick owner, register m_* from owner, m_req=1, go to BUSY.
// - Owner selection: data wins, except fetch wins when if_req=1 and streak==MAX_D_STREAK.
// - Streak counter:
//   - +1 on each data grant made while if_req=1 (saturates at MAX_D_STREAK).
//   - Cleared on any fetch grant and whenever if_req=0.
// - BUSY:
//   - m_* held stable.
//   - Timeout counter +1 each cycle.
//   - On m_ack: capture m_rdata, m_req=0, go to RESP.
//   - Else if TIMEOUT!=0 and count==TIMEOUT: m_req=0, set owner err, go to RESP.
// - RESP: owner valid=1 (with err if aborted) for exactly one cycle, then IDLE.
//   - Owner req is ignored in RESP; the other requester waits.
// - Fetch data: if_rdata = if_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
// - Fetch uses m_we=0 and m_wstrb=0; if_addr[1:0] is ignored.
// - Latency: request sampled at edge N -> m_req high after N.
//   - Ack at edge N+1 -> valid high after edge N+2.
//   - Minimum 3 cycles per transaction.
// - Simultaneous if_req and d_req in IDLE: exactly one grant; the loser stays stalled.
// - m_ack outside BUSY is ignored.
// - rst in any state: next edge returns IDLE; m_req=0; no valid pulse.
//   - An in-flight access is dropped and memory must tolerate the withdrawn request.
// - Errors, rdata and valid are held 0 outside RESP.
// TESTING
// - Fetch @0x4, m_ack 1 cycle after m_req, m_rdata=0x00B00213_00000013
//   -> if_rdata=0x00B00213, if_valid pulse 2 edges after sample, if_err=0.
// - if_req and d_req (read @0x10) rise together -> data granted first, d_valid
//   -> fetch granted in the cycle after RESP; stall_if high throughout.
// - MAX_D_STREAK=2, d_req continuous, if_req held -> grants D,D,F,D,D,F.
// - TIMEOUT=4, d_req with no m_ack -> m_req drops after 4 BUSY cycles
//   -> d_valid=1, d_err=1 for 1 cycle.
// - Write d_addr=0x1005, d_wdata=0xDEADBEEF, d_wstrb=0x0F
//   -> m_we=1, m_addr=0x1000, m_wstrb=0x0F, m_wdata=0xDEADBEEF.
// - rst asserted during BUSY -> m_req=0 and FSM IDLE after next edge
//   -> no if_valid or d_valid pulse follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (32-bit, read-only) and the
// MEM stage (64-bit read/write), with data priority, a starvation guard and an ack timeout.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    input  logic [7:0]  d_wstrb_i,
    output logic [63:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_err_o,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [63:0] m_addr_o,
    output logic [63:0] m_wdata_o,
    output logic [7:0]  m_wstrb_o,
    input  logic        m_ack_i,
    input  logic [63:0] m_rdata_i
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW:0]   TO_LIM     = (TW+1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q;
    logic [TW-1:0] tcnt_q;
    logic          owner_d_q;
    logic          sel_hi_q;
    logic          m_req_q;
    logic          m_we_q;
    logic [63:0]   m_addr_q;
    logic [63:0]   m_wdata_q;
    logic [7:0]    m_wstrb_q;
    logic [31:0]   if_rdata_q;
    logic          if_valid_q;
    logic          if_err_q;
    logic [63:0]   d_rdata_q;
    logic          d_valid_q;
    logic          d_err_q;

    logic force_f_s;
    logic grant_d_s;
    logic to_hit_s;
    logic unused_s;

    assign unused_s = ^{if_addr_i[1:0], d_addr_i[2:0]};

    // Owner selection and timeout detection
    always_comb begin
        force_f_s = 1'b0;
        to_hit_s  = 1'b0;
        if ((MAX_D_STREAK != 0) && if_req_i && (streak_q == STREAK_MAX)) begin
            force_f_s = 1'b1;
        end else begin
            force_f_s = 1'b0;
        end
        grant_d_s = d_req_i & ~force_f_s;
        if ((TIMEOUT != 0) && (({1'b0, tcnt_q} + {{TW{1'b0}}, 1'b1}) == TO_LIM)) begin
            to_hit_s = 1'b1;
        end else begin
            to_hit_s = 1'b0;
        end
    end

    // Transaction FSM with registered memory-side and response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            tcnt_q     <= '0;
            owner_d_q  <= 1'b0;
            sel_hi_q   <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 64'd0;
            m_wdata_q  <= 64'd0;
            m_wstrb_q  <= 8'd0;
            if_rdata_q <= 32'd0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= 64'd0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            // The streak only counts data grants that actually made fetch wait.
            if (!if_req_i) begin
                streak_q <= '0;
            end else if (state_q == IDLE && !grant_d_s) begin
                streak_q <= '0;
            end else if (state_q == IDLE && grant_d_s && streak_q != STREAK_MAX) begin
                streak_q <= streak_q + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                streak_q <= streak_q;
            end

            case (state_q)
                IDLE: begin
                    if (if_req_i || d_req_i) begin
                        state_q   <= BUSY;
                        m_req_q   <= 1'b1;
                        tcnt_q    <= '0;
                        owner_d_q <= grant_d_s;
                        sel_hi_q  <= if_addr_i[2];
                        if (grant_d_s) begin
                            m_we_q    <= d_we_i;
                            m_addr_q  <= {d_addr_i[63:3], 3'b000};
                            m_wdata_q <= d_wdata_i;
                            m_wstrb_q <= d_we_i ? d_wstrb_i : 8'd0;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= {if_addr_i[63:3], 3'b000};
                            m_wdata_q <= 64'd0;
                            m_wstrb_q <= 8'd0;
                        end
                    end
                end
                BUSY: begin
                    if (m_ack_i) begin
                        state_q <= RESP;
                        m_req_q <= 1'b0;
                        if (owner_d_q) begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= m_rdata_i;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= sel_hi_q ? m_rdata_i[63:32] : m_rdata_i[31:0];
                        end
                    end else if (to_hit_s) begin
                        state_q <= RESP;
                        m_req_q <= 1'b0;
                        if (owner_d_q) begin
                            d_valid_q <= 1'b1;
                            d_err_q   <= 1'b1;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_err_q   <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    if_valid_q <= 1'b0;
                    if_err_q   <= 1'b0;
                    if_rdata_q <= 32'd0;
                    d_valid_q  <= 1'b0;
                    d_err_q    <= 1'b0;
                    d_rdata_q  <= 64'd0;
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_req_o     = m_req_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_wstrb_o   = m_wstrb_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_err_o    = if_err_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign d_err_o     = d_err_q;
    assign stall_if_o  = if_req_i & ~if_valid_q;
    assign stall_mem_o = d_req_i & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, starvation guard and reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wstrb;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        stall_if;
    logic        stall_mem;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_ack;
    logic [63:0] m_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MAX_D_STREAK(2), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_valid_o(if_valid), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wstrb_i(d_wstrb), .d_rdata_o(d_rdata), .d_valid_o(d_valid), .d_err_o(d_err),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem),
        .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_wstrb_o(m_wstrb), .m_ack_i(m_ack), .m_rdata_i(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] mrdata;
        int          ack_dly;
        logic [63:0] exp_maddr;
        logic        exp_mwe;
        logic [7:0]  exp_mwstrb;
        logic [63:0] exp_mwdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_mreq(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req && n < 10);
        check(name, 64'(n), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        m_rdata = v.mrdata;
        wait_mreq($sformatf("v%0d_mreq_latency", idx));
        check($sformatf("v%0d_m_addr", idx), m_addr, v.exp_maddr);
        check($sformatf("v%0d_m_we", idx), {63'd0, m_we}, {63'd0, v.exp_mwe});
        check($sformatf("v%0d_m_wstrb", idx), {56'd0, m_wstrb}, {56'd0, v.exp_mwstrb});
        check($sformatf("v%0d_m_wdata", idx), m_wdata, v.exp_mwdata);
        check($sformatf("v%0d_stall_busy", idx), {63'd0, v.is_d ? stall_mem : stall_if}, 64'd1);
        if (v.ack_dly > 0) begin
            repeat (v.ack_dly) @(negedge clk);
            m_ack = 1'b1;
            @(negedge clk);
            m_ack = 1'b0;
        end else begin
            n = 1;
            while (m_req && n < 20) begin
                @(negedge clk);
                if (m_req) n++;
            end
            check($sformatf("v%0d_timeout_cycles", idx), 64'(n), 64'd4);
        end
        check($sformatf("v%0d_m_req_dropped", idx), {63'd0, m_req}, 64'd0);
        if (v.is_d) begin
            check($sformatf("v%0d_d_valid", idx), {63'd0, d_valid}, 64'd1);
            check($sformatf("v%0d_d_err", idx), {63'd0, d_err}, {63'd0, v.exp_err});
            check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_rdata);
            check($sformatf("v%0d_if_valid_quiet", idx), {63'd0, if_valid}, 64'd0);
            check($sformatf("v%0d_stall_mem_resp", idx), {63'd0, stall_mem}, 64'd0);
        end else begin
            check($sformatf("v%0d_if_valid", idx), {63'd0, if_valid}, 64'd1);
            check($sformatf("v%0d_if_err", idx), {63'd0, if_err}, {63'd0, v.exp_err});
            check($sformatf("v%0d_if_rdata", idx), {32'd0, if_rdata}, v.exp_rdata);
            check($sformatf("v%0d_d_valid_quiet", idx), {63'd0, d_valid}, 64'd0);
            check($sformatf("v%0d_stall_if_resp", idx), {63'd0, stall_if}, 64'd0);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = 64'd0; d_wstrb = 8'd0;
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", idx), {62'd0, if_valid, d_valid}, 64'd0);
        check($sformatf("v%0d_err_cleared", idx), {62'd0, if_err, d_err}, 64'd0);
        check($sformatf("v%0d_rdata_cleared", idx), d_rdata | {32'd0, if_rdata}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic exp_grant [6];
        logic got_grant;
        logic any_valid;

        vecs[0] = '{1'b0, 1'b0, 64'h4, 64'h0, 8'h00, 64'h00B00213_00000013, 1,
                    64'h0, 1'b0, 8'h00, 64'h0, 64'h00B00213, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 64'h11112222_33334444, 1,
                    64'h1000, 1'b0, 8'h00, 64'h0, 64'h33334444, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 64'h7, 64'h0, 8'h00, 64'hAAAABBBB_CCCCDDDD, 3,
                    64'h0, 1'b0, 8'h00, 64'h0, 64'hAAAABBBB, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 64'h10, 64'h0, 8'hFF, 64'h01234567_89ABCDEF, 1,
                    64'h10, 1'b0, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 64'h1005, 64'hDEADBEEF, 8'h0F, 64'h0, 1,
                    64'h1000, 1'b1, 8'h0F, 64'hDEADBEEF, 64'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 64'h18, 64'h0, 8'h00, 64'h5555_5555_5555_5555, -1,
                    64'h18, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 64'h2C, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, -1,
                    64'h28, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 64'h0, 2,
                    64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 8'h80, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};

        rst = 1'b1; if_req = 1'b0; if_addr = 64'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 64'd0; d_wdata = 64'd0; d_wstrb = 8'd0; m_ack = 1'b0; m_rdata = 64'd0;
        repeat (3) @(negedge clk);
        check("reset_m_req", {63'd0, m_req}, 64'd0);
        check("reset_m_addr", m_addr, 64'd0);
        check("reset_m_strobe_we", {55'd0, m_wstrb, m_we}, 64'd0);
        check("reset_valids", {60'd0, if_valid, if_err, d_valid, d_err}, 64'd0);
        check("reset_rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Simultaneous requests: data first, fetch granted after RESP.
        if_req = 1'b1; if_addr = 64'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
        @(negedge clk);
        check("sim_first_mreq", {63'd0, m_req}, 64'd1);
        check("sim_first_owner_addr", m_addr, 64'h10);
        check("sim_stall_if_busy", {63'd0, stall_if}, 64'd1);
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 64'h0BAD_F00D_1234_5678;
        @(negedge clk);
        m_ack = 1'b0;
        check("sim_d_valid", {63'd0, d_valid}, 64'd1);
        check("sim_d_rdata", d_rdata, 64'h0BAD_F00D_1234_5678);
        check("sim_if_valid_quiet", {63'd0, if_valid}, 64'd0);
        check("sim_stall_if_resp", {63'd0, stall_if}, 64'd1);
        d_req = 1'b0;
        @(negedge clk);
        check("sim_idle_gap_mreq", {63'd0, m_req}, 64'd0);
        check("sim_stall_if_idle", {63'd0, stall_if}, 64'd1);
        @(negedge clk);
        check("sim_fetch_mreq", {63'd0, m_req}, 64'd1);
        check("sim_fetch_addr", m_addr, 64'h20);
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 64'hCAFEF00D_12345678;
        @(negedge clk);
        m_ack = 1'b0;
        check("sim_if_valid", {63'd0, if_valid}, 64'd1);
        check("sim_if_rdata", {32'd0, if_rdata}, 64'h12345678);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Starvation guard with MAX_D_STREAK=2: D,D,F,D,D,F.
        exp_grant = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        if_req = 1'b1; if_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        m_rdata = 64'd0;
        for (int g = 0; g < 6; g++) begin
            wait_mreq($sformatf("streak_mreq_latency_%0d", g));
            got_grant = (m_addr == 64'h100);
            check($sformatf("streak_grant_%0d", g), {63'd0, got_grant}, {63'd0, exp_grant[g]});
            @(negedge clk);
            m_ack = 1'b1;
            @(negedge clk);
            m_ack = 1'b0;
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during BUSY drops the access; stray acks afterwards are ignored.
        d_req = 1'b1; d_addr = 64'h40; m_rdata = 64'h1111_2222_3333_4444;
        wait_mreq("rst_mreq_latency");
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_m_req", {63'd0, m_req}, 64'd0);
        rst = 1'b0; d_req = 1'b0; m_ack = 1'b1;
        any_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_valid || d_valid || m_req) any_valid = 1'b1;
            if (c == 2) m_ack = 1'b0;
        end
        check("rst_no_pulse_after", {63'd0, any_valid}, 64'd0);
        run_vec(vecs[0], 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
